m_pc_fetch: RTL

- Program counter and instruction-fetch stage of the CPU datapath.
- Consumes the branch comparator's equality flag and the sign-extended 32-bit immediate.
- Computes the next PC: sequential, taken branch, or jump.
- Runs a request/ready handshake with instruction memory and presents each fetched instruction downstream under a stall handshake.

---
 rtl/m_pc_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/m_pc_fetch.sv
// m_pc_fetch: program counter and instruction-fetch stage.
// Runs a two-phase fetch: FETCH (request/ready with instruction memory),
// then ISSUE (hold the instruction downstream until stall drops, then step the PC).
// Optional misalignment trap is enabled by defining M_PC_FETCH_MISALIGN_TRAP_EN.
module m_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch,
    input  logic        equal,
    input  logic [31:0] imm_ext,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        misalign
);

`ifdef M_PC_FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_TRAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] seq_pc;
    logic [31:0] imm_bytes;
    logic [31:0] next_pc;
    logic        req_fsm;

    // Next-PC selection: jump beats a taken branch, which beats sequential flow.
    always_comb begin
        seq_pc    = pc_q + 32'd4;
        imm_bytes = imm_ext << 2;
        if (jump) begin
            next_pc = jump_addr;
        end else if (branch && equal) begin
            next_pc = seq_pc + imm_bytes;
        end else begin
            next_pc = seq_pc;
        end
    end

    // FSM next-state, register next values and handshake outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        req_fsm     = 1'b0;
        instr_valid = 1'b0;
        misalign    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_fsm = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
`ifdef M_PC_FETCH_MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
`else
                    // Without the trap, a misaligned target is silently word-aligned.
                    pc_d    = next_pc & ~32'd3;
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef M_PC_FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                // Sticky until reset.
                misalign = 1'b1;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, PC and instruction latch with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // The request is masked while reset is held so memory sees no fetch during reset.
    assign imem_req  = req_fsm & ~reset;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign pc_plus4  = seq_pc;
    assign instr     = instr_q;

endmodule
